forward_publisher: RTL and testbench

//  Producer side of the forwarding network: one instance per pipeline stage

---
 rtl/defs.sv | 24 ++
 rtl/forward_tag_match.sv | 20 ++
 rtl/forward_publisher.sv | 122 ++++++++++++
 tb/tb_forward_publisher.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/defs.sv
// Shared forwarding-network types: register address, the published forward
// port, and the publisher entry state.
package defs;

    localparam int FWD_DATA_W = 32;

    typedef logic [4:0] RegAddr;

    localparam RegAddr REG_ZERO = 5'b00000;

    typedef struct packed {
        RegAddr                addr;
        logic                  write;
        logic                  eval;
        logic [FWD_DATA_W-1:0] value;
    } ForwardPort;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } PubState_t;

endpackage

// File: rtl/forward_tag_match.sv
// Late-result tag compare and same-cycle bypass of the late value over the
// held value.
module forward_tag_match #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3
) (
    input  logic              in_wait,
    input  logic              late_valid,
    input  logic [TAG_W-1:0]  late_tag,
    input  logic [TAG_W-1:0]  tag,
    input  logic [DATA_W-1:0] late_value,
    input  logic [DATA_W-1:0] held_value,
    output logic              match,
    output logic [DATA_W-1:0] value
);

    assign match = in_wait & late_valid & (late_tag == tag);
    assign value = match ? late_value : held_value;

endmodule

// File: rtl/forward_publisher.sv
// Holds one stage's pending register write, publishes it on the forwarding
// network, captures a late result by tag and retires the write to writeback.
module forward_publisher
    import defs::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_write,
    input  logic [4:0]        in_addr,
    input  logic              in_eval,
    input  logic [DATA_W-1:0] in_value,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              late_valid,
    input  logic [TAG_W-1:0]  late_tag,
    input  logic [DATA_W-1:0] late_value,
    output ForwardPort        port,
    output logic              stall_req,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_value,
    output logic [CNT_W-1:0]  wait_cycles,
    output PubState_t         state
);

    PubState_t         state_q;
    PubState_t         state_d;
    RegAddr            addr_q;
    logic [DATA_W-1:0] value_q;
    logic [TAG_W-1:0]  tag_q;

    logic              match;
    logic              resolved;
    logic              load;
    logic              load_write;
    logic [DATA_W-1:0] eff_value;

    forward_tag_match #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_tag_match (
        .in_wait    (state_q == WAIT),
        .late_valid (late_valid),
        .late_tag   (late_tag),
        .tag        (tag_q),
        .late_value (late_value),
        .held_value (value_q),
        .match      (match),
        .value      (eff_value)
    );

    assign resolved   = (state_q == DONE) | match;
    assign stall_req  = (state_q == WAIT) & ~match;
    assign load       = ~hold & ~stall_req;
    // Register 0 is hardwired, so a write to it is treated as a bubble.
    assign load_write = in_valid & in_write & (in_addr != REG_ZERO);
    assign state      = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            value_q     <= '0;
            tag_q       <= '0;
            wait_cycles <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wait_cycles <= '0;
            end else if (load) begin
                wait_cycles <= '0;
                if (load_write) begin
                    addr_q  <= in_addr;
                    value_q <= in_value;
                    tag_q   <= in_tag;
                end
            end else if (match) begin
                value_q <= late_value;
            end else if (state_q == WAIT && wait_cycles != '1) begin
                wait_cycles <= wait_cycles + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (load) begin
            if (load_write) state_d = in_eval ? DONE : WAIT;
            else            state_d = IDLE;
        end else if (match) begin
            state_d = DONE;
        end
    end

    always_comb begin
        port     = '0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_value = '0;
        if (state_q != IDLE) begin
            port.addr  = addr_q;
            port.write = 1'b1;
            port.eval  = resolved;
            port.value = eff_value;
        end
        // The entry leaves only when the stage advances and replaces it.
        if (resolved && !hold && !flush) begin
            wb_valid = 1'b1;
            wb_addr  = port.addr;
            wb_value = port.value;
        end
    end

endmodule

// File: tb/tb_forward_publisher.sv
// Directed bench for forward_publisher: load, late capture, tag mismatch,
// flush, register-0 writes, counter saturation and reset.
module tb_forward_publisher;
    import defs::*;

    logic             clock = 1'b0;
    logic             reset;
    logic             hold;
    logic             flush;
    logic             in_valid;
    logic             in_write;
    logic [4:0]       in_addr;
    logic             in_eval;
    logic [31:0]      in_value;
    logic [2:0]       in_tag;
    logic             late_valid;
    logic [2:0]       late_tag;
    logic [31:0]      late_value;
    ForwardPort       port;
    logic             stall_req;
    logic             wb_valid;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_value;
    logic [7:0]       wait_cycles;
    PubState_t        state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    forward_publisher #(.DATA_W(32), .TAG_W(3), .CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .hold        (hold),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_write    (in_write),
        .in_addr     (in_addr),
        .in_eval     (in_eval),
        .in_value    (in_value),
        .in_tag      (in_tag),
        .late_valid  (late_valid),
        .late_tag    (late_tag),
        .late_value  (late_value),
        .port        (port),
        .stall_req   (stall_req),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_value    (wb_value),
        .wait_cycles (wait_cycles),
        .state       (state)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] fp(input logic [4:0] a, input logic w, input logic e,
                                       input logic [31:0] v);
        ForwardPort p;
        p.addr  = a;
        p.write = w;
        p.eval  = e;
        p.value = v;
        return 64'(p);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        hold = 0; flush = 0; in_valid = 0; in_write = 0; in_addr = 0;
        in_eval = 0; in_value = 0; in_tag = 0;
        late_valid = 0; late_tag = 0; late_value = 0;
    endtask

    task automatic load(input logic [4:0] a, input logic e, input logic [31:0] v,
                        input logic [2:0] t);
        in_valid = 1; in_write = 1; in_addr = a; in_eval = e; in_value = v; in_tag = t;
        step();
        idle_inputs();
        #1;
    endtask

    task automatic check_quiet(input string name);
        check({name, ".port"},  64'(port), 64'd0);
        check({name, ".wb"},    {62'd0, wb_valid, stall_req}, 64'd0);
        check({name, ".wbdat"}, {27'd0, wb_addr, wb_value}, 64'd0);
        check({name, ".wait"},  64'(wait_cycles), 64'd0);
        check({name, ".state"}, 64'(state), 64'(IDLE));
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        #1;
        check_quiet("reset");

        // Final-value load publishes next cycle and retires.
        load(5'd5, 1'b1, 32'h1234, 3'd0);
        check("t1.port",  64'(port), fp(5'd5, 1, 1, 32'h1234));
        check("t1.wb",    {27'd0, wb_addr, wb_value}, {27'd0, 5'd5, 32'h1234});
        check("t1.wbv",   {62'd0, wb_valid, stall_req}, 64'd2);
        check("t1.state", 64'(state), 64'(DONE));
        step();
        check_quiet("t1.bubble");

        // Pending load, late result after three stalled cycles.
        load(5'd7, 1'b0, 32'h0, 3'd2);
        check("t2.port0", 64'(port), fp(5'd7, 1, 0, 32'h0));
        check("t2.c0", {54'd0, wait_cycles, wb_valid, stall_req}, {54'd0, 8'd0, 1'b0, 1'b1});
        step();
        check("t2.c1", {54'd0, wait_cycles, wb_valid, stall_req}, {54'd0, 8'd1, 1'b0, 1'b1});
        step();
        check("t2.c2", {54'd0, wait_cycles, wb_valid, stall_req}, {54'd0, 8'd2, 1'b0, 1'b1});
        step();
        late_valid = 1; late_tag = 3'd2; late_value = 32'hBEEF;
        #1;
        check("t2.port", 64'(port), fp(5'd7, 1, 1, 32'hBEEF));
        check("t2.c3", {54'd0, wait_cycles, wb_valid, stall_req}, {54'd0, 8'd3, 1'b1, 1'b0});
        check("t2.wb", {27'd0, wb_addr, wb_value}, {27'd0, 5'd7, 32'hBEEF});
        step();
        idle_inputs();
        #1;
        check_quiet("t2.retired");

        // Mismatched tag is ignored; matching tag under hold captures only.
        load(5'd9, 1'b0, 32'h0, 3'd2);
        late_valid = 1; late_tag = 3'd3; late_value = 32'h5555;
        #1;
        check("t3.mis", {61'd0, port.eval, wb_valid, stall_req}, 64'd1);
        step();
        check("t3.state", 64'(state), 64'(WAIT));
        check("t3.wait",  {55'd0, wait_cycles, stall_req}, {55'd0, 8'd1, 1'b1});
        late_tag = 3'd2; late_value = 32'hAAAA; hold = 1;
        #1;
        check("t3.hport", 64'(port), fp(5'd9, 1, 1, 32'hAAAA));
        check("t3.hwb",   {62'd0, wb_valid, stall_req}, 64'd0);
        step();
        late_valid = 0; late_value = 32'h0;
        #1;
        check("t3.held", 64'(port), fp(5'd9, 1, 1, 32'hAAAA));
        check("t3.hs",   {54'd0, 64'(state) == 64'(DONE), wait_cycles, wb_valid}, {54'd1, 8'd1, 1'b0});
        hold = 0;
        #1;
        check("t3.wb", {26'd0, wb_valid, wb_addr, wb_value}, {26'd0, 1'b1, 5'd9, 32'hAAAA});
        step();
        check_quiet("t3.retired");

        // Flush a pending entry; its late result must be ignored.
        load(5'd3, 1'b0, 32'h0, 3'd1);
        flush = 1;
        #1;
        check("t4.fwb", {63'd0, wb_valid}, 64'd0);
        step();
        flush = 0;
        late_valid = 1; late_tag = 3'd1; late_value = 32'h77;
        #1;
        check_quiet("t4.late");
        step();
        idle_inputs();
        #1;
        check_quiet("t4.after");

        // Flush suppresses writeback of a resolved entry.
        load(5'd4, 1'b1, 32'hCAFE, 3'd0);
        flush = 1;
        #1;
        check("t4.dflush", {62'd0, wb_valid, port.write}, 64'd1);
        step();
        flush = 0;
        #1;
        check_quiet("t4.dafter");

        // Register 0 never publishes.
        load(5'd0, 1'b1, 32'hFFFF, 3'd0);
        check_quiet("t5.r0");

        // Wait counter saturates at all-ones.
        load(5'd8, 1'b0, 32'h0, 3'd4);
        for (int i = 0; i < 300; i++) step();
        check("t6.sat", {55'd0, wait_cycles, stall_req}, {55'd0, 8'hFF, 1'b1});

        // Reset wins over a same-cycle late match.
        late_valid = 1; late_tag = 3'd4; late_value = 32'h99;
        reset = 1;
        step();
        reset = 0;
        idle_inputs();
        #1;
        check_quiet("t6.reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
